// File: rtl/mem_bus_arbiter.sv
// Two-port (A = fetch, B = data/DMA) arbiter and sequencer for the single memory unit port.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int ADDR_W         = 27,
   parameter int DATA_W         = 32,
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_we,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_q,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_we,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_q,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   output logic              mem_start,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] mem_q,
   input  logic              mem_init_done,
   output logic              grant_b,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic              grant_b_q, grant_b_d;
   logic              last_b_q, last_b_d;
   logic [DATA_W-1:0] a_rd_q, a_rd_d;
   logic [DATA_W-1:0] b_rd_q, b_rd_d;
   logic              start;
   logic              pick_b;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   // B wins only when alone, or on a round-robin tie after A held the bus last
   assign pick_b = b_req && (!a_req || (FIXED_PRIO == 0 && !last_b_q));

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      we_d      = we_q;
      grant_b_d = grant_b_q;
      last_b_d  = last_b_q;
      a_rd_d    = a_rd_q;
      b_rd_d    = b_rd_q;
      start     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (mem_init_done && (a_req || b_req)) begin
               addr_d    = pick_b ? b_addr : a_addr;
               data_d    = pick_b ? b_data : a_data;
               we_d      = pick_b ? b_we   : a_we;
               grant_b_d = pick_b;
               last_b_d  = pick_b;
               state_d   = ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         ISSUE: begin
            start = 1'b1;
            if (mem_busy) state_d = WAIT;
         end
         WAIT: begin
            start = 1'b1;
            if (!mem_busy) begin
               if (grant_b_q) b_rd_d = mem_q;
               else           a_rd_d = mem_q;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;  // DONE: start already low before the memory's negedge
      endcase
`ifdef MEM_ARB_TIMEOUT_EN
      if (state_q == ISSUE || state_q == WAIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            start   = 1'b0;
            if (grant_b_q) b_rd_d = '0;
            else           a_rd_d = '0;
            err_d   = 1'b1;
            state_d = DONE;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         we_q      <= 1'b0;
         grant_b_q <= 1'b0;
         last_b_q  <= 1'b1;
         a_rd_q    <= '0;
         b_rd_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         we_q      <= we_d;
         grant_b_q <= grant_b_d;
         last_b_q  <= last_b_d;
         a_rd_q    <= a_rd_d;
         b_rd_q    <= b_rd_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign mem_address = addr_q;
   assign mem_data    = data_q;
   assign mem_we      = we_q;
   assign mem_start   = start;
   assign grant_b     = grant_b_q;
   assign a_q         = a_rd_q;
   assign b_q         = b_rd_q;
   assign a_ack       = (state_q == DONE) && !grant_b_q;
   assign b_ack       = (state_q == DONE) &&  grant_b_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; a second FIXED_PRIO=1 instance shares the requester inputs.
module tb_mem_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
   logic [26:0] a_addr = '0, b_addr = '0;
   logic [31:0] a_data = '0, b_data = '0;
   logic        init_done = 1'b0;

   logic        a_ack, b_ack, mem_we, mem_start, grant_b, timeout_err;
   logic [31:0] a_q, b_q, mem_data;
   logic [26:0] mem_address;
   logic        f_a_ack, f_b_ack, f_mem_we, f_mem_start, f_grant_b, f_timeout_err;
   logic [31:0] f_a_q, f_b_q, f_mem_data;
   logic [26:0] f_mem_address;

   // memory model (negedge), one per instance
   logic        m_busy = 1'b0, m_we = 1'b0;
   logic [31:0] m_q = '0;
   int          m_rem = 0;
   int          busy_len = 1;
   bit          never_busy = 1'b0;
   logic [31:0] rd_val = '0;
   logic        f_busy = 1'b0, f_we = 1'b0;
   logic [31:0] f_q = '0;

   typedef struct { bit port; logic [31:0] q; } exp_t;
   exp_t sb[$];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(27), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) u_dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_ack(a_ack), .a_q(a_q),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_ack(b_ack), .b_q(b_q),
      .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_start(mem_start),
      .mem_busy(m_busy), .mem_q(m_q), .mem_init_done(init_done),
      .grant_b(grant_b), .timeout_err(timeout_err));

   mem_bus_arbiter #(.ADDR_W(27), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(1024)) u_fix (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_ack(f_a_ack), .a_q(f_a_q),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_ack(f_b_ack), .b_q(f_b_q),
      .mem_address(f_mem_address), .mem_data(f_mem_data), .mem_we(f_mem_we), .mem_start(f_mem_start),
      .mem_busy(f_busy), .mem_q(f_q), .mem_init_done(init_done),
      .grant_b(f_grant_b), .timeout_err(f_timeout_err));

   always @(negedge clk) begin
      if (m_busy) begin
         if (m_rem <= 1) begin
            m_busy <= 1'b0;
            m_q    <= m_we ? 32'h0 : rd_val;
         end
         m_rem <= m_rem - 1;
      end else if (mem_start && !never_busy) begin
         m_busy <= 1'b1;
         m_rem  <= busy_len;
         m_we   <= mem_we;
      end
   end

   always @(negedge clk) begin
      if (f_busy) begin
         f_busy <= 1'b0;
         f_q    <= f_we ? 32'h0 : 32'h1;
      end else if (f_mem_start) begin
         f_busy <= 1'b1;
         f_we   <= f_mem_we;
      end
   end

   // waits on negedges for an ack from u_dut; reports which port and its q
   task automatic wait_ack(input int budget, output bit got, output bit port,
                           output logic [31:0] q, output int cyc);
      got = 1'b0; port = 1'b0; q = '0; cyc = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         cyc++;
         if (a_ack || b_ack) begin
            got = 1'b1; port = b_ack; q = b_ack ? b_q : a_q;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", mem_start); end
      total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", {a_ack, b_ack}); end
      total++; if (a_q !== 32'h0 || b_q !== 32'h0) begin bad++; $display("FAIL rst_q got=%h/%h exp=0/0", a_q, b_q); end
      total++; if (mem_address !== 27'h0 || mem_data !== 32'h0 || mem_we !== 1'b0) begin
         bad++; $display("FAIL rst_mem got=%h/%h/%b exp=0/0/0", mem_address, mem_data, mem_we); end
      total++; if (grant_b !== 1'b0) begin bad++; $display("FAIL rst_grant_b got=%b exp=0", grant_b); end
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic test_init_and_read;
      bit got, port; logic [31:0] q; int cyc, errs;
      exp_t e;
      rd_val = 32'hDEADBEEF; busy_len = 1;
      a_addr = 27'h000123; a_we = 1'b0; a_req = 1'b1;
      errs = 0;
      repeat (6) begin @(negedge clk); if (mem_start !== 1'b0 || a_ack !== 1'b0) errs++; end
      total++; if (errs != 0) begin bad++; $display("FAIL init_hold got=%0d starts exp=0", errs); end
      @(posedge clk); #1 init_done = 1'b1;
      sb.push_back('{1'b0, 32'hDEADBEEF});
      @(negedge clk);
      @(negedge clk);
      total++; if (mem_start !== 1'b1 || mem_address !== 27'h000123) begin
         bad++; $display("FAIL grant_a got start=%b addr=%h exp 1/000123", mem_start, mem_address); end
      wait_ack(20, got, port, q, cyc);
      a_req = 1'b0;
      total++; if (!got || cyc + 2 != 4) begin bad++; $display("FAIL latency got=%0d/%0d exp=1/4", got, cyc + 2); end
      e = sb.pop_front();
      total++; if (port !== e.port || q !== e.q) begin
         bad++; $display("FAIL read_a got=%0d:%h exp=%0d:%h", port, q, e.port, e.q); end
      total++; if (b_q !== 32'h0) begin bad++; $display("FAIL b_q_kept got=%h exp=0", b_q); end
      @(negedge clk);
      total++; if (a_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse got=%b exp=0", a_ack); end
   endtask

   task automatic test_write_b;
      int starts, errs, i, spur; bit done;
      exp_t e;
      busy_len = 5;
      @(posedge clk); #1;
      b_addr = 27'hC02630; b_data = 32'h0000AB00; b_we = 1'b1; b_req = 1'b1;
      sb.push_back('{1'b1, 32'h0});
      starts = 0; errs = 0; done = 1'b0; i = 0;
      while (!done && i < 30) begin
         @(negedge clk); i++;
         if (i == 2) begin a_req = 1'b1; a_addr = 27'h55; a_we = 1'b0; end
         if (i == 4) a_req = 1'b0;
         if (mem_start) begin
            starts++;
            if (mem_we !== 1'b1 || grant_b !== 1'b1 || mem_address !== 27'hC02630 || mem_data !== 32'h0000AB00)
               errs++;
         end
         if (a_ack || b_ack) begin
            done = 1'b1; b_req = 1'b0;
            e = sb.pop_front();
            total++; if (b_ack !== 1'b1 || a_ack !== 1'b0 || b_q !== e.q) begin
               bad++; $display("FAIL write_b_ack got=%b%b:%h exp=01:%h", a_ack, b_ack, b_q, e.q); end
            total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL write_b_stop got=%b exp=0", mem_start); end
         end
      end
      total++; if (!done) begin bad++; $display("FAIL write_b_timeout got=no ack exp=ack"); end
      total++; if (starts != 6) begin bad++; $display("FAIL write_b_span got=%0d exp=6", starts); end
      total++; if (errs != 0) begin bad++; $display("FAIL write_b_hold got=%0d errs exp=0", errs); end
      spur = 0;
      repeat (8) begin @(negedge clk); if (a_ack || b_ack || mem_start) spur++; end
      total++; if (spur != 0) begin bad++; $display("FAIL withdraw got=%0d events exp=0", spur); end
      total++; if (grant_b !== 1'b1) begin bad++; $display("FAIL grant_b_hold got=%b exp=1", grant_b); end
      b_we = 1'b0;
   endtask

   task automatic test_round_robin;
      int n, fa, fb, dual; bit stop;
      exp_t e;
      busy_len = 1; rd_val = 32'h0BADF00D;
      a_addr = 27'h10; b_addr = 27'h20; a_we = 1'b0; b_we = 1'b0;
      sb.push_back('{1'b0, 32'h0BADF00D}); sb.push_back('{1'b1, 32'h0BADF00D});
      sb.push_back('{1'b0, 32'h0BADF00D}); sb.push_back('{1'b1, 32'h0BADF00D});
      @(posedge clk); #1 a_req = 1'b1; b_req = 1'b1;
      n = 0; fa = 0; fb = 0; dual = 0; stop = 1'b0;
      for (int i = 0; i < 40 && !stop; i++) begin
         @(negedge clk);
         if (a_ack && b_ack) dual++;
         if (f_a_ack) fa++;
         if (f_b_ack) fb++;
         if (a_ack || b_ack) begin
            e = sb.pop_front();
            total++; if (b_ack !== e.port || (b_ack ? b_q : a_q) !== e.q) begin
               bad++; $display("FAIL rr_%0d got=%0d:%h exp=%0d:%h", n, b_ack, b_ack ? b_q : a_q, e.port, e.q); end
            n++;
            if (n == 4) begin stop = 1'b1; a_req = 1'b0; b_req = 1'b0; end
         end
      end
      total++; if (n != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", n); end
      total++; if (dual != 0) begin bad++; $display("FAIL one_ack got=%0d exp=0", dual); end
      total++; if (fb != 0 || fa < 2) begin bad++; $display("FAIL fixed_prio got a=%0d b=%0d exp a>=2 b=0", fa, fb); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int spur, w; bit got, port; logic [31:0] q; int cyc;
      exp_t e;
      busy_len = 8; rd_val = 32'h13572468; a_addr = 27'h77; a_we = 1'b0;
      @(posedge clk); #1 a_req = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (mem_start !== 1'b1 || m_busy !== 1'b1) begin
         bad++; $display("FAIL mid_wait got=%b%b exp=11", mem_start, m_busy); end
      @(posedge clk); #1 reset = 1'b1; a_req = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      total++; if (mem_start !== 1'b0 || a_ack !== 1'b0 || a_q !== 32'h0) begin
         bad++; $display("FAIL mid_abort got start=%b ack=%b q=%h exp 0/0/0", mem_start, a_ack, a_q); end
      spur = 0;
      repeat (10) begin @(negedge clk); if (a_ack || b_ack || mem_start) spur++; end
      total++; if (spur != 0) begin bad++; $display("FAIL mid_noack got=%0d exp=0", spur); end
      w = 0;
      while (m_busy && w < 20) begin @(negedge clk); w++; end
      busy_len = 1;
      @(posedge clk); #1 a_req = 1'b1;
      sb.push_back('{1'b0, 32'h13572468});
      wait_ack(20, got, port, q, cyc);
      a_req = 1'b0;
      e = sb.pop_front();
      total++; if (!got || cyc != 4 || port !== e.port || q !== e.q) begin
         bad++; $display("FAIL post_reset got=%0d cyc=%0d %0d:%h exp=1 cyc=4 %0d:%h", got, cyc, port, q, e.port, e.q); end
      @(negedge clk);
   endtask

   task automatic test_timeout;
`ifdef MEM_ARB_TIMEOUT_EN
      bit got, port; logic [31:0] q; int cyc;
      exp_t e;
      never_busy = 1'b1; a_addr = 27'h99; a_we = 1'b0;
      @(posedge clk); #1 a_req = 1'b1;
      sb.push_back('{1'b0, 32'h0});
      wait_ack(40, got, port, q, cyc);
      a_req = 1'b0;
      e = sb.pop_front();
      total++; if (!got || cyc != 18 || port !== e.port || q !== e.q) begin
         bad++; $display("FAIL timeout got=%0d cyc=%0d %0d:%h exp=1 cyc=18 %0d:%h", got, cyc, port, q, e.port, e.q); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", timeout_err); end
      never_busy = 1'b0; rd_val = 32'h2468ACE0;
      @(posedge clk); #1 b_req = 1'b1; b_we = 1'b0;
      sb.push_back('{1'b1, 32'h2468ACE0});
      wait_ack(20, got, port, q, cyc);
      b_req = 1'b0;
      e = sb.pop_front();
      total++; if (!got || port !== e.port || q !== e.q) begin
         bad++; $display("FAIL after_timeout got=%0d:%h exp=%0d:%h", port, q, e.port, e.q); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", timeout_err); end
`else
      @(negedge clk);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_tied got=%b exp=0", timeout_err); end
`endif
   endtask

   initial begin
      test_reset();
      test_init_and_read();
      test_write_b();
      test_round_robin();
      test_reset_mid();
      test_timeout();
      total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_left got=%0d exp=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single CPU-side memory unit port (address/data/we/start, busy/q, initDone).
- Port A is instruction fetch; port B is data/DMA.
- Grants one requester at a time, drives the start-held-until-busy-low handshake, captures read data and returns a one-cycle ack.
- Runs on posedge clk; the memory unit runs on negedge of the same clock.

Parameters:
- ADDR_W, 27, address width.
- DATA_W, 32, data width.
- FIXED_PRIO, 0, arbitration policy: 0 = round-robin; 1 = A always wins ties.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- a_req  in  1  port A request; addr/data/we stable while high
- a_addr  in  ADDR_W  port A address
- a_data  in  DATA_W  port A write data
- a_we  in  1  port A write enable
- a_ack  out  1  one-cycle completion pulse
- a_q  out  DATA_W  read data, valid when a_ack=1
- b_req, b_addr, b_data, b_we, b_ack, b_q: same as port A, for port B
- mem_address  out  ADDR_W  to memory unit
- mem_data  out  DATA_W  to memory unit
- mem_we  out  1  to memory unit
- mem_start  out  1  to memory unit
- mem_busy  in  1  from memory unit
- mem_q  in  DATA_W  from memory unit
- mem_init_done  in  1  from memory unit
- grant_b  out  1  1 while port B owns the bus (status)
- timeout_err  out  1  sticky watchdog flag (macro only; tied 0 otherwise)

Behaviour:
- Reset values: state=IDLE, mem_start=0, mem_we=0, mem_address=0, mem_data=0, a_ack=b_ack=0, a_q=b_q=0, grant_b=0, last_grant=B (so A wins the first tie).
- Reset asserted mid-transaction: abort to IDLE next edge; no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No grant while mem_init_done=0.
  - Otherwise sample a_req/b_req. One requester → grant it. Both → round-robin (grant opposite of last_grant), or A if FIXED_PRIO=1.
  - On grant: register addr/data/we into mem_* outputs, set grant_b, update last_grant, go ISSUE.
- ISSUE: mem_start=1. mem_busy=1 → WAIT; otherwise stay.
- WAIT: mem_start=1. mem_busy=0 → latch mem_q into the granted port's q register, go DONE.
- DONE:
  - mem_start=0; pulse the granted port's ack for exactly 1 cycle; go IDLE.
  - Deasserting mem_start here, before the next negedge, prevents the memory unit from re-triggering.
- mem_we held for the whole ISSUE..WAIT span; mem_* outputs held stable from grant through DONE.
- Latency: minimum 4 cycles from req to ack with a 1-negedge memory response (IDLE→ISSUE→WAIT→DONE).
- Writes also complete through WAIT→DONE; q carries whatever the memory unit returns (0 for most writes).
- Requester semantics:
  - If req is still high in the cycle after ack, it is treated as a new request.
  - req dropped before grant: request is withdrawn with no effect.
  - req dropped after grant: transaction completes; ack is still pulsed.
- Simultaneous req from both ports while a transaction is in flight: both wait; arbitration happens only in IDLE.
- Only one ack can be high in any cycle.
- grant_b holds its last value while in IDLE.
- q registers of the non-granted port are unchanged.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in ISSUE and WAIT.
  - On reaching TIMEOUT_CYCLES-1: force mem_start=0, load q=0 for the granted port, go DONE (ack pulses), set timeout_err=1.
  - timeout_err stays set until reset.
  - Counter clears on every grant.
- Not defined: no counter; ISSUE/WAIT wait indefinitely; timeout_err tied 0.

Test Plan:
- mem_init_done=0, a_req=1 → mem_start stays 0. Raise init_done → grant A; mem_address=a_addr; a_ack 4 cycles later.
- A read 0x000123, memory model returns 0xDEADBEEF after 1 negedge → a_q=0xDEADBEEF with a_ack=1 for exactly one cycle; b_q unchanged.
- a_req and b_req held continuously, FIXED_PRIO=0 → grants alternate A,B,A,B. Repeat with FIXED_PRIO=1 → A only; B starved.
- B write 0xC02630 data 0x0000AB00, memory model busy for 5 cycles → mem_start and mem_we high through WAIT, drop the cycle after busy falls; b_ack pulses; grant_b=1 during the transaction.
- Reset asserted in WAIT → next cycle IDLE, mem_start=0, no ack; a new request after reset is served normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, memory never asserts busy → after 16 cycles a_ack=1, a_q=0, timeout_err=1; it stays set through later good transactions.
